// File: rtl/nand_op_sequencer.sv
// Universal bitwise logic unit: seven functions built by time-multiplexing a
// single WIDTH-bit NAND datapath, one evaluation per RUN cycle.

module nandGate (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = ~(a_i & b_i);
endmodule

module nand_op_sequencer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic {S_IDLE, S_RUN} state_e;
  typedef enum logic [1:0] {SRC_A, SRC_B, SRC_T1, SRC_T2} src_e;
  typedef enum logic [1:0] {DST_T1, DST_T2, DST_Y, DST_NONE} dst_e;

  state_e           state_q, state_d;
  logic [2:0]       step_q, step_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] t1_q, t1_d, t2_q, t2_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             done_q, done_d, err_q, err_d;

  src_e             src_x, src_y;
  dst_e             dst;
  logic             last;
  logic [WIDTH-1:0] x_w, yin_w, nand_w;

  // Step program: step_q holds (step number - 1) of the step executed at the next edge.
  always_comb begin
    src_x = SRC_A;
    src_y = SRC_B;
    dst   = DST_Y;
    last  = 1'b1;
    case (op_q)
      3'd0: ;
      3'd1: src_y = SRC_A;
      3'd2: begin
        if (step_q == 3'd0) begin
          dst  = DST_T1;
          last = 1'b0;
        end else begin
          src_x = SRC_T1;
          src_y = SRC_T1;
        end
      end
      3'd3, 3'd4: begin
        case (step_q)
          3'd0: begin src_x = SRC_A; src_y = SRC_A; dst = DST_T1; last = 1'b0; end
          3'd1: begin src_x = SRC_B; src_y = SRC_B; dst = DST_T2; last = 1'b0; end
          3'd2: begin
            src_x = SRC_T1;
            src_y = SRC_T2;
            if (op_q == 3'd4) begin
              dst  = DST_T1;
              last = 1'b0;
            end
          end
          default: begin src_x = SRC_T1; src_y = SRC_T1; end
        endcase
      end
      3'd5, 3'd6: begin
        case (step_q)
          3'd0: begin src_x = SRC_A; src_y = SRC_B;  dst = DST_T1; last = 1'b0; end
          3'd1: begin src_x = SRC_A; src_y = SRC_T1; dst = DST_T2; last = 1'b0; end
          3'd2: begin src_x = SRC_B; src_y = SRC_T1; dst = DST_T1; last = 1'b0; end
          3'd3: begin
            src_x = SRC_T2;
            src_y = SRC_T1;
            if (op_q == 3'd6) begin
              dst  = DST_T1;
              last = 1'b0;
            end
          end
          default: begin src_x = SRC_T1; src_y = SRC_T1; end
        endcase
      end
      default: dst = DST_NONE;
    endcase
  end

  always_comb begin
    case (src_x)
      SRC_A:   x_w = a_q;
      SRC_B:   x_w = b_q;
      SRC_T1:  x_w = t1_q;
      default: x_w = t2_q;
    endcase
    case (src_y)
      SRC_A:   yin_w = a_q;
      SRC_B:   yin_w = b_q;
      SRC_T1:  yin_w = t1_q;
      default: yin_w = t2_q;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_nand
    nandGate u_nand (
      .a_i (x_w[i]),
      .b_i (yin_w[i]),
      .y_o (nand_w[i])
    );
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    t1_d    = t1_q;
    t2_d    = t2_q;
    y_d     = y_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          step_d  = '0;
          state_d = S_RUN;
        end
      end
      default: begin
        case (dst)
          DST_T1:  t1_d = nand_w;
          DST_T2:  t2_d = nand_w;
          DST_Y:   y_d  = nand_w;
          default: y_d  = '0;
        endcase
        if (last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = (dst == DST_NONE);
        end else begin
          step_d = step_q + 3'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      y_q     <= y_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign y    = y_q;
  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign err  = err_q;

endmodule
